mem_access_unit: RTL

Requester-side controller for the single-port data memory: accepts load and fill (store) commands over a valid/ready handshake, then drives the memory's address, write-data, read-enable and write-enable ports one beat per cycle. It aligns the memory's registered one-cycle read data with a response stream. It sits between the datapath/load-store logic and `data_memory`. It is the initiator end of that memory interface.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_access_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and widths for the data-memory access path
package mem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        FILL = 1'b1
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        DRAIN = 2'd3
    } mau_state_e;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

endpackage

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - burst load/fill requester for the single-port data memory
import mem_pkg::*;

module mem_access_unit #(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    mau_state_e        state_q;
    mau_state_e        state_d;
    mem_op_e           op_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              rd_d;
    logic              last_d;
    logic              fill_ack;
    logic              is_fill;

    assign is_fill = (mem_op_e'(req_op) == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = is_fill ? WR : RD;
            RD, WR:  if (cnt_q == '0) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data arrives one cycle after the strobe, so the response is
    // tagged by the delayed strobe and the memory data is passed straight through.
    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        fill_ack   = (state_q == DRAIN) && (op_q == FILL);
        resp_valid = rd_d | fill_ack;
        resp_data  = rd_d ? mem_read_data : '0;
        resp_last  = last_d | fill_ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q           <= LOAD;
            cnt_q          <= '0;
            rd_d           <= 1'b0;
            last_d         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            rd_d   <= mem_read;
            last_d <= mem_read && (cnt_q == '0);
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q           <= mem_op_e'(req_op);
                        cnt_q          <= req_len;
                        mem_addr       <= req_addr;
                        mem_write_data <= is_fill ? req_wdata : '0;
                        mem_read       <= !is_fill;
                        mem_write      <= is_fill;
                    end
                end
                RD, WR: begin
                    if (cnt_q == '0) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q - 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
